// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: RX byte commands (0xCC A B FUN / 0xDD FUN) become one ALU_EN pulse and a two-byte TX response (lo, hi).
// Latency: FUN strobe -> ALU_EN next cycle; TX_D_VLD one cycle after ALU_OUT_VALID. TX byte held while TX_READY=0.
// Define ALU_CMD_SEQ_TIMEOUT_EN to bound WAIT_RES to 15 cycles; the result then becomes 0x00EE.
module alu_cmd_seq #(
    parameter int D_WIDTH   = 8,
    parameter int FUN_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [D_WIDTH-1:0]     RX_P_DATA,
    input  logic                   RX_D_VLD,
    output logic [D_WIDTH-1:0]     ALU_A,
    output logic [D_WIDTH-1:0]     ALU_B,
    output logic [FUN_WIDTH-1:0]   ALU_FUN,
    output logic                   ALU_EN,
    input  logic [2*D_WIDTH-1:0]   ALU_OUT,
    input  logic                   ALU_OUT_VALID,
    output logic [D_WIDTH-1:0]     TX_P_DATA,
    output logic                   TX_D_VLD,
    input  logic                   TX_READY,
    output logic                   BUSY
);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI
    } state_t;

    localparam logic [D_WIDTH-1:0] CMD_NEW   = D_WIDTH'(8'hCC);
    localparam logic [D_WIDTH-1:0] CMD_REUSE = D_WIDTH'(8'hDD);

    state_t               state;
    logic [2*D_WIDTH-1:0] result;

`ifdef ALU_CMD_SEQ_TIMEOUT_EN
    localparam logic [2*D_WIDTH-1:0] TIMEOUT_RES = (2*D_WIDTH)'(8'hEE);
    logic [3:0] wait_cnt;
`endif

    // Response byte is a select of the result register, so it cannot move while the FSM waits on TX_READY.
    assign TX_P_DATA = (state == SEND_HI) ? result[2*D_WIDTH-1:D_WIDTH] : result[D_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_FUN  <= '0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;
            BUSY     <= 1'b0;
            result   <= '0;
`ifdef ALU_CMD_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (RX_D_VLD && RX_P_DATA == CMD_NEW) begin
                        state <= GET_A;
                        BUSY  <= 1'b1;
                    end else if (RX_D_VLD && RX_P_DATA == CMD_REUSE) begin
                        state <= GET_FUN;
                        BUSY  <= 1'b1;
                    end
                end
                GET_A: begin
                    if (RX_D_VLD) begin
                        ALU_A <= RX_P_DATA;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (RX_D_VLD) begin
                        ALU_B <= RX_P_DATA;
                        state <= GET_FUN;
                    end
                end
                GET_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        ALU_EN  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    ALU_EN <= 1'b0;
                    state  <= WAIT_RES;
`ifdef ALU_CMD_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT_RES: begin
                    if (ALU_OUT_VALID) begin
                        result   <= ALU_OUT;
                        TX_D_VLD <= 1'b1;
                        state    <= SEND_LO;
                    end
`ifdef ALU_CMD_SEQ_TIMEOUT_EN
                    // Count 14 means this is the 15th cycle without a result.
                    else if (wait_cnt == 4'd14) begin
                        result   <= TIMEOUT_RES;
                        TX_D_VLD <= 1'b1;
                        state    <= SEND_LO;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                SEND_LO: begin
                    if (TX_READY) begin
                        state <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (TX_READY) begin
                        TX_D_VLD <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: directed scenarios plus randomized commands checked against a command-level model.
`timescale 1ns/1ps
module tb_alu_cmd_seq;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VALID;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_READY;
    logic        BUSY;

    alu_cmd_seq #(.D_WIDTH(8), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
        .BUSY(BUSY)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Command-level model: operands as last sent by the bench.
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [3:0] m_f = 4'h0;

    int          alu_delay   = 1;
    bit          alu_respond = 1'b1;
    int          force_req   = 0;
    int          rsp_seen    = 0;
    logic [15:0] force_val   = 16'h0;
    logic [15:0] rsp_val;
    bit          rand_ready  = 1'b0;

    int         en_pulses = 0;
    logic [7:0] tx_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return {a, b} ^ {12'h000, f};
        endcase
    endfunction

    // ALU stand-in: answers each ALU_EN after alu_delay cycles, or on an explicit force request.
    initial begin
        ALU_OUT       = 16'h0;
        ALU_OUT_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (force_req != rsp_seen) begin
                rsp_seen = force_req;
                rsp_val  = force_val;
                @(posedge CLK); #1;
                ALU_OUT = rsp_val; ALU_OUT_VALID = 1'b1;
                @(posedge CLK); #1;
                ALU_OUT_VALID = 1'b0; ALU_OUT = 16'($urandom);
            end else if (ALU_EN === 1'b1 && alu_respond) begin
                rsp_val = alu_fn(ALU_A, ALU_B, ALU_FUN);
                repeat (alu_delay) @(posedge CLK);
                #1;
                ALU_OUT = rsp_val; ALU_OUT_VALID = 1'b1;
                @(posedge CLK); #1;
                ALU_OUT_VALID = 1'b0; ALU_OUT = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (ALU_EN === 1'b1) en_pulses++;
            if (TX_D_VLD === 1'b1 && TX_READY === 1'b1) tx_q.push_back(TX_P_DATA);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            if (rand_ready) TX_READY = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    // Sends a full command; returns in the ISSUE cycle with the model's expected 16-bit result.
    task automatic do_cmd(input bit reuse, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f, output logic [15:0] exp);
        if (!reuse) begin
            send_byte(8'hCC); send_byte(a); send_byte(b);
            m_a = a; m_b = b;
        end else begin
            send_byte(8'hDD);
        end
        send_byte({4'($urandom), f});
        m_f = f;
        exp = alu_fn(m_a, m_b, m_f);
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (tx_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        ok = (tx_q.size() >= n);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(2);
        n_cmp++; if (ALU_A !== 8'h00 || ALU_B !== 8'h00 || ALU_FUN !== 4'h0) begin n_err++;
            $display("FAIL reset_operands: got A=%h B=%h F=%h want 0/0/0", ALU_A, ALU_B, ALU_FUN); end
        n_cmp++; if (ALU_EN !== 1'b0 || TX_D_VLD !== 1'b0 || BUSY !== 1'b0) begin n_err++;
            $display("FAIL reset_ctrl: got en=%b tvld=%b busy=%b want 0/0/0", ALU_EN, TX_D_VLD, BUSY); end
        n_cmp++; if (TX_P_DATA !== 8'h00) begin n_err++;
            $display("FAIL reset_tx_data: got %h want 00", TX_P_DATA); end
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_mul;
        int base; bit ok; logic [15:0] exp;
        base = en_pulses; tx_q.delete();
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h02);
        m_a = 8'h05; m_b = 8'h03; m_f = 4'h2; exp = 16'h000F;
        n_cmp++; if (ALU_EN !== 1'b1 || BUSY !== 1'b1) begin n_err++;
            $display("FAIL mul_issue: got en=%b busy=%b want 1/1", ALU_EN, BUSY); end
        n_cmp++; if (ALU_A !== 8'h05 || ALU_B !== 8'h03 || ALU_FUN !== 4'h2) begin n_err++;
            $display("FAIL mul_operands: got %h/%h/%h want 05/03/2", ALU_A, ALU_B, ALU_FUN); end
        tick(1);
        n_cmp++; if (ALU_EN !== 1'b0 || TX_D_VLD !== 1'b0) begin n_err++;
            $display("FAIL mul_wait_res: got en=%b tvld=%b want 0/0", ALU_EN, TX_D_VLD); end
        tick(1);
        n_cmp++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== exp[7:0]) begin n_err++;
            $display("FAIL mul_latency: got tvld=%b data=%h want 1/%h", TX_D_VLD, TX_P_DATA, exp[7:0]); end
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== 8'h0F || tx_q[1] !== 8'h00) begin n_err++;
            $display("FAIL mul_tx: got %0d bytes want 0F,00", tx_q.size()); end
        n_cmp++; if (en_pulses - base !== 1 || BUSY !== 1'b0) begin n_err++;
            $display("FAIL mul_done: got pulses=%0d busy=%b want 1/0", en_pulses - base, BUSY); end
    endtask

    task automatic test_reuse;
        bit ok; logic [15:0] exp;
        tx_q.delete();
        do_cmd(1'b1, 8'h00, 8'h00, 4'h0, exp);
        n_cmp++; if (ALU_A !== 8'h05 || ALU_B !== 8'h03 || ALU_FUN !== 4'h0 || ALU_EN !== 1'b1) begin n_err++;
            $display("FAIL reuse_operands: got %h/%h/%h en=%b want 05/03/0 en=1", ALU_A, ALU_B, ALU_FUN, ALU_EN); end
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== 8'h08 || tx_q[1] !== 8'h00) begin n_err++;
            $display("FAIL reuse_tx: got %0d bytes want 08,00", tx_q.size()); end
    endtask

    task automatic test_ignore;
        int base; bit ok; logic [15:0] exp;
        base = en_pulses; tx_q.delete();
        send_byte(8'h55);
        n_cmp++; if (BUSY !== 1'b0) begin n_err++;
            $display("FAIL ignore_busy: got %b want 0", BUSY); end
        tick(3);
        n_cmp++; if (BUSY !== 1'b0 || en_pulses !== base) begin n_err++;
            $display("FAIL ignore_idle: got busy=%b pulses=%0d want 0/%0d", BUSY, en_pulses, base); end
        do_cmd(1'b1, 8'h00, 8'h00, 4'h1, exp);
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== exp[7:0] || tx_q[1] !== exp[15:8]) begin n_err++;
            $display("FAIL ignore_followup: got %0d bytes want %h,%h", tx_q.size(), exp[7:0], exp[15:8]); end
    endtask

    task automatic test_backpressure;
        bit ok; bit seen; bit stable; logic [15:0] exp; int k;
        tx_q.delete();
        TX_READY = 1'b0;
        do_cmd(1'b0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 4)), exp);
        k = 0;
        while (TX_D_VLD !== 1'b1 && k < 20) begin tick(1); k++; end
        seen = (TX_D_VLD === 1'b1);
        n_cmp++; if (!seen) begin n_err++;
            $display("FAIL bp_vld: got tvld=%b want 1 within 20 cycles", TX_D_VLD); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) send_byte(8'hCC); else tick(1);
            if (TX_D_VLD !== 1'b1 || TX_P_DATA !== exp[7:0]) stable = 1'b0;
        end
        n_cmp++; if (!stable) begin n_err++;
            $display("FAIL bp_hold: got tvld=%b data=%h want 1/%h", TX_D_VLD, TX_P_DATA, exp[7:0]); end
        TX_READY = 1'b1;
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== exp[7:0] || tx_q[1] !== exp[15:8]) begin n_err++;
            $display("FAIL bp_tx: got %0d bytes want %h,%h", tx_q.size(), exp[7:0], exp[15:8]); end
        n_cmp++; if (BUSY !== 1'b0 || ALU_A !== m_a || ALU_B !== m_b) begin n_err++;
            $display("FAIL bp_drop: got busy=%b A=%h B=%h want 0/%h/%h", BUSY, ALU_A, ALU_B, m_a, m_b); end
    endtask

    task automatic test_reset_mid;
        int base; bit ok; bit bad; logic [15:0] exp;
        base = en_pulses;
        alu_delay = 6;
        do_cmd(1'b0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'h0, exp);
        tick(2);
        RST = 1'b1;
        tick(1);
        m_a = 8'h00; m_b = 8'h00; m_f = 4'h0;
        n_cmp++; if (ALU_A !== 8'h00 || ALU_B !== 8'h00 || ALU_FUN !== 4'h0 || ALU_EN !== 1'b0) begin n_err++;
            $display("FAIL rstmid_alu: got %h/%h/%h en=%b want 0", ALU_A, ALU_B, ALU_FUN, ALU_EN); end
        n_cmp++; if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h00 || BUSY !== 1'b0) begin n_err++;
            $display("FAIL rstmid_tx: got tvld=%b data=%h busy=%b want 0", TX_D_VLD, TX_P_DATA, BUSY); end
        RST = 1'b0;
        tx_q.delete();
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad || tx_q.size() != 0 || en_pulses - base !== 1) begin n_err++;
            $display("FAIL rstmid_late: got bad=%b tx=%0d pulses=%0d want 0/0/1", bad, tx_q.size(), en_pulses - base); end
        alu_delay = 1;
        do_cmd(1'b1, 8'h00, 8'h00, 4'h0, exp);
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== 8'h00 || tx_q[1] !== 8'h00 || ALU_A !== 8'h00) begin n_err++;
            $display("FAIL rstmid_lost: got %0d bytes A=%h want 00,00 A=00", tx_q.size(), ALU_A); end
    endtask

    task automatic test_timeout;
        bit ok; bit early; logic [15:0] exp;
        tx_q.delete();
        alu_respond = 1'b0;
        do_cmd(1'b0, 8'($urandom), 8'($urandom), 4'h2, exp);
`ifdef ALU_CMD_SEQ_TIMEOUT_EN
        tick(1);
        early = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (TX_D_VLD !== 1'b0) early = 1'b1;
        end
        n_cmp++; if (early) begin n_err++;
            $display("FAIL timeout_early: got tvld=1 before 15 cycles want 0"); end
        tick(1);
        n_cmp++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hEE) begin n_err++;
            $display("FAIL timeout_edge: got tvld=%b data=%h want 1/EE", TX_D_VLD, TX_P_DATA); end
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== 8'hEE || tx_q[1] !== 8'h00) begin n_err++;
            $display("FAIL timeout_tx: got %0d bytes want EE,00", tx_q.size()); end
`else
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (TX_D_VLD !== 1'b0 || BUSY !== 1'b1) early = 1'b1;
        end
        n_cmp++; if (early) begin n_err++;
            $display("FAIL wait_forever: got tvld=%b busy=%b want 0/1 for 40 cycles", TX_D_VLD, BUSY); end
        force_val = 16'hA55A;
        force_req++;
        wait_tx(2, 20, ok);
        n_cmp++; if (!ok || tx_q[0] !== 8'h5A || tx_q[1] !== 8'hA5) begin n_err++;
            $display("FAIL wait_late_result: got %0d bytes want 5A,A5", tx_q.size()); end
`endif
        alu_respond = 1'b1;
        tick(2);
    endtask

    task automatic test_random;
        int base; bit ok; bit reuse; logic [15:0] exp; logic [7:0] junk;
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tx_q.delete();
            base = en_pulses;
            alu_delay = $urandom_range(1, 4);
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'hCC || junk == 8'hDD) junk = junk ^ 8'h01;
                send_byte(junk);
            end
            reuse = ($urandom_range(0, 2) == 0);
            do_cmd(reuse, 8'($urandom), 8'($urandom), 4'($urandom), exp);
            wait_tx(2, 100, ok);
            n_cmp++; if (!ok || tx_q[0] !== exp[7:0] || tx_q[1] !== exp[15:8]) begin n_err++;
                $display("FAIL rand_tx[%0d]: got %0d bytes want %h,%h", i, tx_q.size(), exp[7:0], exp[15:8]); end
            n_cmp++; if (ALU_A !== m_a || ALU_B !== m_b || ALU_FUN !== m_f || en_pulses - base !== 1) begin n_err++;
                $display("FAIL rand_state[%0d]: got %h/%h/%h pulses=%0d want %h/%h/%h 1",
                         i, ALU_A, ALU_B, ALU_FUN, en_pulses - base, m_a, m_b, m_f); end
            tick($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        TX_READY = 1'b1;
    endtask

    initial begin
        RST       = 1'b1;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_READY  = 1'b1;
        test_reset;
        test_mul;
        test_reuse;
        test_ignore;
        test_backpressure;
        test_reset_mid;
        test_timeout;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, which is the operand and RX/TX byte width.
REQ-002 The block SHALL have parameter FUN_WIDTH, default 4, which is the ALU function code width.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port RX_P_DATA, input, D_WIDTH bits: the received command/operand byte.
REQ-006 The block SHALL have port RX_D_VLD, input, 1 bit: RX_P_DATA is valid this cycle (single-cycle strobe per byte).
REQ-007 The block SHALL have port ALU_A, output, D_WIDTH bits: the registered operand A to the ALU.
REQ-008 The block SHALL have port ALU_B, output, D_WIDTH bits: the registered operand B to the ALU.
REQ-009 The block SHALL have port ALU_FUN, output, FUN_WIDTH bits: the registered function code to the ALU.
REQ-010 The block SHALL have port ALU_EN, output, 1 bit: the ALU enable, a single-cycle pulse.
REQ-011 The block SHALL have port ALU_OUT, input, 2*D_WIDTH bits: the ALU result.
REQ-012 The block SHALL have port ALU_OUT_VALID, input, 1 bit: ALU_OUT is valid this cycle.
REQ-013 The block SHALL have port TX_P_DATA, output, D_WIDTH bits: the response byte.
REQ-014 The block SHALL have port TX_D_VLD, output, 1 bit: TX_P_DATA is valid.
REQ-015 The block SHALL have port TX_READY, input, 1 bit: the transmitter accepts the byte when TX_D_VLD and TX_READY are both 1 in the same cycle.
REQ-016 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI.
REQ-018 In IDLE, an RX byte 0xCC SHALL go to GET_A, an RX byte 0xDD SHALL go to GET_FUN, and any other byte SHALL be ignored (no state change).
REQ-019 GET_A and GET_B SHALL each capture the next RX byte into ALU_A and ALU_B respectively, then advance; 0xDD reuses the last ALU_A/ALU_B.
REQ-020 GET_FUN SHALL capture RX_P_DATA[FUN_WIDTH-1:0] into ALU_FUN, then go to ISSUE.
REQ-021 ISSUE SHALL assert ALU_EN for exactly one cycle, then go to WAIT_RES; ALU_A, ALU_B and ALU_FUN SHALL be stable from ISSUE until the next capture.
REQ-022 WAIT_RES SHALL latch ALU_OUT into a 2*D_WIDTH result register on the first cycle ALU_OUT_VALID=1, then go to SEND_LO.
REQ-023 SEND_LO SHALL drive TX_D_VLD=1 with TX_P_DATA = result[D_WIDTH-1:0] and go to SEND_HI on handshake; SEND_HI SHALL drive the upper byte and return to IDLE on handshake.
REQ-024 TX_P_DATA SHALL be held stable while TX_D_VLD=1 and TX_READY=0.
REQ-025 RX bytes arriving in ISSUE, WAIT_RES, SEND_LO or SEND_HI SHALL be dropped.
REQ-026 ALU_OUT_VALID outside WAIT_RES SHALL be ignored.
REQ-027 The minimum latency from the FUN byte strobe to the first TX_D_VLD SHALL be 3 cycles when the ALU responds 1 cycle after ALU_EN (ISSUE, WAIT_RES, then SEND_LO).

Reset
REQ-028 With RST=1 at a rising edge, the state SHALL go to IDLE, and ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY and the result register SHALL be 0.
REQ-029 Reset mid-operation (any state) SHALL abort the operation with no further ALU_EN or TX_D_VLD, and the stored operands SHALL be lost.

Configuration
REQ-030 With macro ALU_CMD_SEQ_TIMEOUT_EN defined, a 4-bit counter SHALL run in WAIT_RES.
REQ-031 With ALU_CMD_SEQ_TIMEOUT_EN defined, if ALU_OUT_VALID has not arrived after 15 cycles the result SHALL be forced to 0x00EE and the FSM SHALL go to SEND_LO.
REQ-032 With ALU_CMD_SEQ_TIMEOUT_EN undefined, WAIT_RES SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-033 The bench SHALL cover: RX 0xCC,0x05,0x03,0x2 with ALU echoing A*B -> one ALU_EN pulse, A=5, B=3, FUN=2; TX 0x0F then 0x00.
REQ-034 The bench SHALL cover: after REQ-033, RX 0xDD,0x0 with ALU adding -> ALU_A/ALU_B unchanged (5/3); TX 0x08 then 0x00.
REQ-035 The bench SHALL cover: RX 0x55 in IDLE -> no state change, BUSY=0, no ALU_EN.
REQ-036 The bench SHALL cover: TX_READY held 0 for 5 cycles in SEND_LO -> TX_D_VLD=1 and TX_P_DATA stable throughout; 0xCC in RX during this time is dropped.
REQ-037 The bench SHALL cover: RST=1 asserted in WAIT_RES -> next cycle all outputs 0, state IDLE; a late ALU_OUT_VALID is ignored.
REQ-038 The bench SHALL cover: with ALU_CMD_SEQ_TIMEOUT_EN defined and no ALU_OUT_VALID -> TX 0xEE then 0x00, starting 15 cycles after WAIT_RES entry.
